mul_seq_ctrl: RTL and testbench

Sequencing front/back end for the shared sequential signed multiplier. It accepts operand pairs on a valid/ready stream and buffers them in a small FIFO. It issues them one at a time to the multiplier's start/A/B/Product/ready port set, then returns each 2*nb-bit product on an output valid/ready stream. It sits directly upstream of the multiplier (feeding start/A/B) and directly downstream of it (consuming Product/ready).

---
 rtl/mul_pkg.sv | 14 +
 rtl/sync_fifo.sv | 50 +++++
 rtl/mul_seq_ctrl.sv | 89 ++++++++
 tb/tb_mul_seq_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared state encoding and default operand width for the multiplier sequencer
package mul_pkg;
  localparam int NB = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_LAUNCH = ST_LAUNCH,
    S_WAIT   = ST_WAIT
  } state_t;
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered count and wrapping head/tail pointers
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // full depends only on the registered count, so a same-cycle pop never frees a slot
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[head];

  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - queues operand pairs, launches the sequential multiplier and returns products
import mul_pkg::*;

module mul_seq_ctrl #(
  parameter int nb    = NB,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [nb-1:0]   in_a,
  input  logic [nb-1:0]   in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*nb-1:0] out_product,
  output logic            mul_start,
  output logic [nb-1:0]   mul_a,
  output logic [nb-1:0]   mul_b,
  input  logic [2*nb-1:0] mul_product,
  input  logic            mul_ready,
  output logic            busy
);
  state_t          state;
  state_t          state_nxt;
  logic [2*nb-1:0] head_pair;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop;
  logic            capture;

  sync_fifo #(.WIDTH(2*nb), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid),
    .push_data ({in_a, in_b}),
    .pop       (pop),
    .pop_data  (head_pair),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign in_ready = !fifo_full;
  assign busy     = (state != S_IDLE) || !fifo_empty;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: state_nxt = S_WAIT;
      S_WAIT: begin
        // mul_ready is meaningless outside WAIT: the multiplier is never reset
        if (mul_ready && (!out_valid || out_ready)) begin
          capture   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      out_valid   <= 1'b0;
      out_product <= '0;
      mul_start   <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
    end else begin
      state     <= state_nxt;
      mul_start <= pop;
      if (pop) {mul_a, mul_b} <= head_pair;
      if (capture) begin
        out_valid   <= 1'b1;
        out_product <= mul_product;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb/tb_mul_seq_ctrl.sv - self-checking bench for mul_seq_ctrl with a behavioural sequential multiplier
module tb_mul_seq_ctrl;
  localparam int NBW = 8;
  localparam int DEP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_product;
  logic        mul_start;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [15:0] mul_product;
  logic        mul_ready;
  logic        busy;

  int pass = 0;
  int total = 0;

  always #5 clk = ~clk;

  mul_seq_ctrl #(.nb(NBW), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_product(mul_product), .mul_ready(mul_ready), .busy(busy)
  );

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[15:0];
  endfunction

  // Sequential multiplier: loads on start, ready again nb edges later, product garbage meanwhile
  int          m_cnt = 0;
  logic [7:0]  m_a = '0;
  logic [7:0]  m_b = '0;
  logic [15:0] m_prod = 16'h0;
  always @(posedge clk) begin
    if (mul_start) begin
      m_cnt  <= NBW;
      m_a    <= mul_a;
      m_b    <= mul_b;
      m_prod <= 16'hDEAD;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_prod <= model(m_a, m_b);
    end
  end
  assign mul_ready   = (m_cnt == 0);
  assign mul_product = m_prod;

  logic [15:0] obs_q[$];
  logic [15:0] exp_q[$];
  int starts = 0;
  int exp_idx = 0;
  int obs_idx = 0;

  always @(negedge clk) begin
    if (out_valid && out_ready) obs_q.push_back(out_product);
    if (mul_start) starts++;
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input bit rnd, output int waited);
    waited = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    while (!in_ready && waited < 300) begin
      @(posedge clk); #1;
      waited++;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
    end
    if (!in_ready) begin
      total++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, waited);
    end else begin
      exp_q.push_back(model(a, b));
      @(posedge clk); #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int guard = 0;
    int n_exp;
    int n_obs;
    out_ready = 1'b1;
    while ((busy || out_valid || obs_q.size() < exp_q.size()) && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    n_exp = exp_q.size() - exp_idx;
    n_obs = obs_q.size() - obs_idx;
    total++;
    if (n_obs != n_exp) $display("FAIL %s_count: got %0d results, required %0d", name, n_obs, n_exp);
    else pass++;
    for (int i = 0; i < n_exp && i < n_obs; i++) begin
      total++;
      if (obs_q[obs_idx+i] !== exp_q[exp_idx+i])
        $display("FAIL %s_result[%0d]: got %h, required %h", name, i, obs_q[obs_idx+i], exp_q[exp_idx+i]);
      else pass++;
    end
    exp_idx = exp_q.size();
    obs_idx = obs_q.size();
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    total += 7;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b, required 0", out_valid); else pass++;
    if (out_product !== 16'h0) $display("FAIL reset_out_product: got %h, required 0000", out_product); else pass++;
    if (mul_start !== 1'b0) $display("FAIL reset_mul_start: got %b, required 0", mul_start); else pass++;
    if (mul_a !== 8'h0) $display("FAIL reset_mul_a: got %h, required 00", mul_a); else pass++;
    if (mul_b !== 8'h0) $display("FAIL reset_mul_b: got %h, required 00", mul_b); else pass++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b, required 1", in_ready); else pass++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy); else pass++;
  endtask

  task automatic test_single;
    int w;
    int k;
    int s0;
    out_ready = 1'b1;
    s0 = starts;
    send(8'd3, 8'hFE, 1'b0, w);
    k = 31;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        k = i;
        break;
      end
    end
    total += 2;
    if (k != 11) $display("FAIL single_latency: out_valid after E0+%0d, required E0+11", k); else pass++;
    if (out_product !== 16'hFFFA) $display("FAIL single_product: got %h, required fffa", out_product); else pass++;
    drain("single");
    total++;
    if (starts - s0 != 1) $display("FAIL single_start_cycles: got %0d, required 1", starts - s0); else pass++;
  endtask

  task automatic test_corners;
    logic [7:0]  ca [4] = '{8'h80, 8'h7F, 8'h00, 8'hFF};
    logic [7:0]  cb [4] = '{8'h80, 8'h80, 8'hFF, 8'hFF};
    logic [15:0] ce [4] = '{16'h4000, 16'hC080, 16'h0000, 16'h0001};
    int base;
    int w;
    out_ready = 1'b1;
    base = obs_q.size();
    for (int i = 0; i < 4; i++) send(ca[i], cb[i], 1'b0, w);
    drain("corners");
    for (int i = 0; i < 4; i++) begin
      total++;
      if (base + i >= obs_q.size()) $display("FAIL corner_const[%0d]: got no result, required %h", i, ce[i]);
      else if (obs_q[base+i] !== ce[i]) $display("FAIL corner_const[%0d]: got %h, required %h", i, obs_q[base+i], ce[i]);
      else pass++;
    end
  endtask

  task automatic test_back_to_back;
    int w;
    int guard = 0;
    out_ready = 1'b1;
    send(8'($urandom()), 8'($urandom()), 1'b0, w);
    while (!mul_start && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    wait_cycles(1);
    for (int i = 0; i < 4; i++) send(8'($urandom()), 8'($urandom()), 1'b0, w);
    total++;
    if (in_ready !== 1'b0) $display("FAIL b2b_full_in_ready: got %b, required 0", in_ready); else pass++;
    send(8'($urandom()), 8'($urandom()), 1'b0, w);
    total++;
    if (w < 1) $display("FAIL b2b_fifth_wait: waited %0d cycles, required >= 1", w); else pass++;
    drain("b2b");
  endtask

  task automatic test_backpressure;
    int w;
    int s0;
    logic [15:0] snap;
    bit stable = 1'b1;
    out_ready = 1'b0;
    s0 = starts;
    send(8'($urandom()), 8'($urandom()), 1'b0, w);
    send(8'($urandom()), 8'($urandom()), 1'b0, w);
    wait_cycles(30);
    total += 2;
    if (out_valid !== 1'b1) $display("FAIL bp_out_valid: got %b, required 1", out_valid); else pass++;
    if (out_product !== exp_q[exp_idx]) $display("FAIL bp_first_held: got %h, required %h", out_product, exp_q[exp_idx]); else pass++;
    snap = out_product;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_product !== snap || out_valid !== 1'b1) stable = 1'b0;
    end
    total += 4;
    if (!stable) $display("FAIL bp_stable: got product %h valid %b, required %h valid 1", out_product, out_valid, snap); else pass++;
    if (mul_ready !== 1'b1) $display("FAIL bp_mul_ready: got %b, required 1", mul_ready); else pass++;
    if (busy !== 1'b1) $display("FAIL bp_busy_parked: got %b, required 1", busy); else pass++;
    if (starts - s0 != 2) $display("FAIL bp_start_count: got %0d, required 2", starts - s0); else pass++;
    drain("bp");
  endtask

  task automatic test_no_bubble;
    int w;
    logic [15:0] second;
    out_ready = 1'b0;
    send(8'($urandom()), 8'($urandom()), 1'b0, w);
    send(8'($urandom()), 8'($urandom()), 1'b0, w);
    second = exp_q[exp_idx+1];
    wait_cycles(30);
    out_ready = 1'b1;
    @(posedge clk); #1;
    total += 2;
    if (out_valid !== 1'b1) $display("FAIL nobubble_valid: got %b, required 1", out_valid); else pass++;
    if (out_product !== second) $display("FAIL nobubble_product: got %h, required %h", out_product, second); else pass++;
    drain("nobubble");
  endtask

  task automatic test_reset_mid;
    int w;
    int guard = 0;
    out_ready = 1'b1;
    send(8'($urandom()), 8'($urandom()), 1'b0, w);
    while (!mul_start && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    wait_cycles(3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(exp_q.pop_back());
    total += 3;
    if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid: got %b, required 0", out_valid); else pass++;
    if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready: got %b, required 1", in_ready); else pass++;
    if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b, required 0", busy); else pass++;
    send(8'd5, 8'd6, 1'b0, w);
    drain("rstmid");
    total++;
    if (obs_q.size() == 0 || obs_q[obs_q.size()-1] !== 16'h001E)
      $display("FAIL rstmid_product: got %h, required 001e", obs_q.size() ? obs_q[obs_q.size()-1] : 16'hxxxx);
    else pass++;
  endtask

  task automatic test_random;
    int w;
    int s0;
    s0 = starts;
    for (int n = 0; n < 24; n++) begin
      int gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      send(8'($urandom()), 8'($urandom()), 1'b1, w);
    end
    drain("random");
    total++;
    if (starts - s0 != 24) $display("FAIL random_start_count: got %0d, required 24", starts - s0); else pass++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(posedge clk); #1;
    test_reset;
    test_single;
    test_corners;
    test_back_to_back;
    test_backpressure;
    test_no_bubble;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
